// File: rtl/instr_realign_buf.sv
// instr_realign_buf: splits aligned fetch blocks into 16/32-bit RV32IC instructions through a halfword FIFO.
module instr_realign_buf #(
  parameter int          FETCH_W  = 32,
  parameter int          DEPTH    = 8,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic [31:0]        flush_pc_i,
  input  logic               fetch_valid_i,
  output logic               fetch_ready_o,
  input  logic [FETCH_W-1:0] fetch_data_i,
  output logic               instr_valid_o,
  input  logic               instr_ready_i,
  output logic [31:0]        instr_o,
  output logic [31:0]        instr_pc_o,
  output logic               instr_compressed_o
);
  localparam int NHW = FETCH_W / 16;
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int DW  = $clog2(FETCH_W / 8) - 1;
  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d, need, push_n;
  logic [31:0]   pc_q, pc_d;
  logic [DW-1:0] drop_q, drop_d;
  logic [15:0]   hw0, hw1;
  logic          comp, push, pop;
  assign hw0                = mem_q[rd_q];
  assign hw1                = mem_q[AW'(rd_q + 1'b1)];
  assign comp               = hw0[1:0] != 2'b11;
  assign need               = comp ? CW'(1) : CW'(2);
  assign instr_valid_o      = cnt_q >= need;
  assign fetch_ready_o      = (CW'(DEPTH) - cnt_q) >= CW'(NHW);
  assign push               = fetch_valid_i & fetch_ready_o & ~flush_i;
  assign pop                = instr_valid_o & instr_ready_i & ~flush_i;
  assign push_n             = CW'(NHW) - CW'(drop_q);
  assign instr_o            = !instr_valid_o ? 32'h0 : comp ? {16'h0, hw0} : {hw1, hw0};
  assign instr_pc_o         = pc_q;
  assign instr_compressed_o = instr_valid_o & comp;
  always_comb begin
    rd_d   = pop ? AW'(rd_q + AW'(need)) : rd_q;
    wr_d   = push ? AW'(wr_q + AW'(push_n)) : wr_q;
    cnt_d  = CW'(cnt_q + (push ? push_n : CW'(0)) - (pop ? need : CW'(0)));
    pc_d   = pop ? pc_q + (comp ? 32'd2 : 32'd4) : pc_q;
    drop_d = push ? '0 : drop_q;
    if (flush_i) begin
      rd_d   = '0;
      wr_d   = '0;
      cnt_d  = '0;
      pc_d   = {flush_pc_i[31:1], 1'b0};
      drop_d = flush_pc_i[DW:1];
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      pc_q   <= RESET_PC;
      drop_q <= '0;
    end else begin
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      cnt_q  <= cnt_d;
      pc_q   <= pc_d;
      drop_q <= drop_d;
    end
  end
  // After a redirect the leading halfwords before the target are skipped, packing the rest at wr_q.
  always_ff @(posedge clk_i) begin
    if (push)
      for (int i = 0; i < NHW; i++)
        if (i >= int'(drop_q))
          mem_q[AW'(wr_q + AW'(i) - AW'(drop_q))] <= fetch_data_i[16*i +: 16];
  end
endmodule

// File: tb/tb_instr_realign_buf.sv
// tb_instr_realign_buf: scoreboard bench for 32-bit and 64-bit fetch configurations of instr_realign_buf.
module tb_instr_realign_buf;
  typedef struct {logic [31:0] i; logic [31:0] pc; logic c;} exp_t;
  logic        clk = 0;
  logic        a_rst = 1, a_fl = 0, a_fv = 0, a_ir = 0, a_fr, a_iv, a_ic;
  logic [31:0] a_fp = 0, a_fd = 0, a_io, a_pc;
  logic        b_rst = 1, b_fl = 0, b_fv = 0, b_ir = 0, b_fr, b_iv, b_ic;
  logic [31:0] b_fp = 0, b_io, b_pc;
  logic [63:0] b_fd = 0;
  exp_t        qa[$], qb[$];
  int          errs = 0, checks = 0;
  always #5 clk = ~clk;
  instr_realign_buf #(.FETCH_W(32), .DEPTH(8), .RESET_PC(32'h0)) u_a (
    .clk_i(clk), .rst_i(a_rst), .flush_i(a_fl), .flush_pc_i(a_fp),
    .fetch_valid_i(a_fv), .fetch_ready_o(a_fr), .fetch_data_i(a_fd),
    .instr_valid_o(a_iv), .instr_ready_i(a_ir), .instr_o(a_io),
    .instr_pc_o(a_pc), .instr_compressed_o(a_ic));
  instr_realign_buf #(.FETCH_W(64), .DEPTH(8), .RESET_PC(32'h0)) u_b (
    .clk_i(clk), .rst_i(b_rst), .flush_i(b_fl), .flush_pc_i(b_fp),
    .fetch_valid_i(b_fv), .fetch_ready_o(b_fr), .fetch_data_i(b_fd),
    .instr_valid_o(b_iv), .instr_ready_i(b_ir), .instr_o(b_io),
    .instr_pc_o(b_pc), .instr_compressed_o(b_ic));
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask
  // Monitors: every accepted instruction is matched against the head of its scoreboard queue.
  always @(negedge clk) begin
    exp_t e;
    if (a_iv && a_ir && !a_fl && !a_rst) begin
      if (qa.size() == 0) chk("a_unexpected_pc", a_pc, 32'hxxxxxxxx);
      else begin
        e = qa.pop_front();
        chk("a_instr", a_io, e.i);
        chk("a_pc", a_pc, e.pc);
        chk("a_comp", {31'b0, a_ic}, {31'b0, e.c});
      end
    end
    if (b_iv && b_ir && !b_fl && !b_rst) begin
      if (qb.size() == 0) chk("b_unexpected_pc", b_pc, 32'hxxxxxxxx);
      else begin
        e = qb.pop_front();
        chk("b_instr", b_io, e.i);
        chk("b_pc", b_pc, e.pc);
        chk("b_comp", {31'b0, b_ic}, {31'b0, e.c});
      end
    end
  end
  task automatic push(input bit sel, input logic [63:0] d);
    int n = 0;
    if (sel) begin b_fv = 1; b_fd = d; end else begin a_fv = 1; a_fd = d[31:0]; end
    @(negedge clk);
    while (!(sel ? b_fr : a_fr) && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("push_timeout", 32'(n), 32'd0);
    @(posedge clk); #1;
    a_fv = 0; b_fv = 0;
  endtask
  task automatic flush_a(input logic [31:0] pc);
    a_fl = 1; a_fp = pc;
    @(posedge clk); #1;
    a_fl = 0;
  endtask
  task automatic drain(input bit sel);
    int n = 0;
    while ((sel ? qb.size() : qa.size()) != 0 && n < 100) begin @(negedge clk); n++; end
    chk("drain_left", 32'(sel ? qb.size() : qa.size()), 32'd0);
    @(posedge clk); #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_valid", {31'b0, a_iv}, 0);
    chk("rst_ready", {31'b0, a_fr}, 1);
    chk("rst_instr", a_io, 0);
    chk("rst_pc", a_pc, 0);
    chk("rst_comp", {31'b0, a_ic}, 0);
    @(posedge clk); #1;
    a_rst = 0; b_rst = 0;
    // 1: two aligned 32-bit instructions
    a_ir = 1;
    qa.push_back('{32'h00000013, 32'h0, 1'b0});
    qa.push_back('{32'h00100093, 32'h4, 1'b0});
    push(0, 64'h00000013);
    push(0, 64'h00100093);
    drain(0);
    // 2: two compressed instructions in one block
    flush_a(32'h0);
    qa.push_back('{32'h00004501, 32'h0, 1'b1});
    qa.push_back('{32'h00004501, 32'h2, 1'b1});
    push(0, 64'h45014501);
    drain(0);
    // 3: 32-bit instruction straddling two blocks
    flush_a(32'h0);
    qa.push_back('{32'h00004501, 32'h0, 1'b1});
    push(0, 64'h00134501);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("straddle_valid", {31'b0, a_iv}, 0);
    chk("straddle_pc", a_pc, 32'h2);
    @(posedge clk); #1;
    qa.push_back('{32'h00000013, 32'h2, 1'b0});
    qa.push_back('{32'h00004501, 32'h6, 1'b1});
    push(0, 64'h45010000);
    drain(0);
    // 4: backpressure until full
    flush_a(32'h0);
    a_ir = 0;
    for (int k = 0; k < 4; k++) qa.push_back('{32'h00000013, 32'(4 * k), 1'b0});
    push(0, 64'h00000013);
    push(0, 64'h00000013);
    push(0, 64'h00000013);
    @(negedge clk);
    chk("six_hw_ready", {31'b0, a_fr}, 1);
    @(posedge clk); #1;
    push(0, 64'h00000013);
    @(negedge clk);
    chk("full_ready", {31'b0, a_fr}, 0);
    chk("full_valid", {31'b0, a_iv}, 1);
    chk("full_instr", a_io, 32'h00000013);
    chk("full_pc", a_pc, 32'h0);
    @(posedge clk); #1;
    a_fv = 1; a_fd = 32'h45014501;
    @(posedge clk); #1;
    a_fv = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("held_instr", a_io, 32'h00000013);
    chk("held_pc", a_pc, 32'h0);
    @(posedge clk); #1;
    a_ir = 1;
    drain(0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("full_no_extra", {31'b0, a_iv}, 0);
    @(posedge clk); #1;
    // 5: flush discards buffered data and drops halfwords before the target
    flush_a(32'h0);
    a_ir = 0;
    push(0, 64'h00100093);
    push(0, 64'h45014501);
    a_ir = 1;
    flush_a(32'h103);
    qa.push_back('{32'h00004501, 32'h102, 1'b1});
    push(0, 64'h45014501);
    drain(0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("flush_empty", {31'b0, a_iv}, 0);
    chk("flush_pc_after", a_pc, 32'h104);
    @(posedge clk); #1;
    // 6: 64-bit fetch, then async reset with 3 halfwords buffered
    b_ir = 1;
    qb.push_back('{32'h00004501, 32'h0, 1'b1});
    qb.push_back('{32'h00004501, 32'h2, 1'b1});
    qb.push_back('{32'h00100093, 32'h4, 1'b0});
    push(1, 64'h00100093_45014501);
    drain(1);
    b_ir = 0;
    qb.push_back('{32'h00004501, 32'h8, 1'b1});
    push(1, 64'h00100093_45014501);
    b_ir = 1;
    @(posedge clk); #1;
    b_ir = 0;
    @(negedge clk);
    chk("b_three_hw_valid", {31'b0, b_iv}, 1);
    chk("b_three_hw_pc", b_pc, 32'hA);
    #2 b_rst = 1;
    #1;
    chk("b_async_valid", {31'b0, b_iv}, 0);
    chk("b_async_pc", b_pc, 32'h0);
    chk("b_async_instr", b_io, 32'h0);
    chk("b_async_ready", {31'b0, b_fr}, 1);
    @(posedge clk); #1;
    b_rst = 0;
    @(negedge clk);
    chk("b_post_rst_valid", {31'b0, b_iv}, 0);
    chk("b_queue_empty", 32'(qb.size()), 0);
    chk("a_queue_empty", 32'(qa.size()), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
